// File: rtl/conv_pkg.sv
// Shared definitions for the convolution feeder and downstream stages.
package conv_pkg;
  localparam int CONV_DATA_W = 32;
  localparam int CONV_TAPS   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } conv_state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: circular buffer, single pointer, read-before-write.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [CONV_DATA_W-1:0] wr_data,
  output logic [CONV_DATA_W-1:0] rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CONV_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          ptr;

  assign rd_data = mem[ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // Contents are deliberately not reset; stale words never reach a window.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= wr_data;
    end
  end
endmodule

// File: rtl/conv_window_streamer.sv
// Raster pixel stream in, serialized 3x3 windows out for the conv accelerator.
//   state | meaning
//   IDLE  | accepting pixels, no window in flight
//   EMIT  | presenting window word tap (0..8), input stalled
//   GAP   | idle strobe cycle, windowDone high, may accept next pixel
module conv_window_streamer
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CONV_DATA_W-1:0] inData,
  input  logic                   inValid,
  output logic                   inReady,
  output logic [CONV_DATA_W-1:0] outData,
  output logic                   outValid,
  output logic                   windowDone,
  output logic                   frameDone
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  conv_state_t            state, state_nxt;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [3:0]             tap;
  logic                   last_win;
  logic                   accept, trigger, col_last, row_last;
  logic [CONV_DATA_W-1:0] l1_out, l0_out;
  logic [CONV_DATA_W-1:0] w [CONV_TAPS];

  assign inReady  = (state != EMIT);
  assign accept   = inValid && inReady;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign trigger  = accept && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  conv_line_buffer #(.DEPTH(IMG_W)) u_line1 (
    .clk     (clk),
    .reset   (reset),
    .en      (accept),
    .wr_data (inData),
    .rd_data (l1_out)
  );

  conv_line_buffer #(.DEPTH(IMG_W)) u_line0 (
    .clk     (clk),
    .reset   (reset),
    .en      (accept),
    .wr_data (l1_out),
    .rd_data (l0_out)
  );

  // Flattened window, index = row*3 + col; row 0 oldest, col 0 oldest.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        w[i*3]   <= w[i*3+1];
        w[i*3+1] <= w[i*3+2];
      end
      w[2] <= l0_out;
      w[5] <= l1_out;
      w[8] <= inData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    outValid   = 1'b0;
    windowDone = 1'b0;
    frameDone  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = EMIT;
      end
      EMIT: begin
        outValid = 1'b1;
        if (tap == 4'(CONV_TAPS - 1)) state_nxt = GAP;
      end
      GAP: begin
        windowDone = 1'b1;
        frameDone  = last_win;
        state_nxt  = trigger ? EMIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // w[1] is loaded at the trigger edge: it becomes w00 once the shift lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap      <= '0;
      outData  <= '0;
      last_win <= 1'b0;
    end else if (trigger) begin
      tap      <= '0;
      outData  <= w[1];
      last_win <= row_last && col_last;
    end else if (state == EMIT) begin
      if (tap != 4'(CONV_TAPS - 1)) begin
        tap     <= tap + 4'd1;
        outData <= w[tap + 4'd1];
      end else begin
        tap <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_streamer.sv
// Bench for conv_window_streamer: 4x4 and 3x3 instances, scoreboard of window words.
module tb_conv_window_streamer;
  import conv_pkg::*;

  typedef struct {
    logic [31:0] pix;
    bit          trig;
    bit          last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, in_valid4, in_ready4, out_valid4, wd4, fd4;
  logic [31:0] in_data4, out_data4;
  logic        rst3, in_valid3, in_ready3, out_valid3, wd3, fd3;
  logic [31:0] in_data3, out_data3;

  conv_window_streamer #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .reset(rst4), .inData(in_data4), .inValid(in_valid4), .inReady(in_ready4),
    .outData(out_data4), .outValid(out_valid4), .windowDone(wd4), .frameDone(fd4)
  );

  conv_window_streamer #(.IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .reset(rst3), .inData(in_data3), .inValid(in_valid3), .inReady(in_ready3),
    .outData(out_data3), .outValid(out_valid3), .windowDone(wd3), .frameDone(fd3)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] q4[$];
  logic [31:0] q3[$];
  int words4 = 0, words3 = 0;
  int wd_cnt4 = 0, fd_cnt4 = 0, wd_cnt3 = 0, fd_cnt3 = 0;
  logic [31:0] img4 [4][4];
  logic [31:0] img3 [3][3];
  vec_t vec4 [16];
  vec_t vec3 [9];
  int first_win [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int coef [9]      = '{0, 0, 0, 0, 32'h0100_0000, 0, 0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst4) begin
      if (out_valid4) begin
        if (q4.size() == 0) check("spurious_word4", 1, 0);
        else check("word4", out_data4, q4.pop_front());
        check("ready_during_emit4", in_ready4, 0);
        words4++;
      end
      if (wd4) begin
        wd_cnt4++;
        check("words_per_window4", words4, 9);
        words4 = 0;
      end
      if (fd4) begin
        fd_cnt4++;
        check("fd_with_wd4", wd4, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst3) begin
      if (out_valid3) begin
        if (q3.size() == 0) check("spurious_word3", 1, 0);
        else check("word3", out_data3, q3.pop_front());
        check("ready_during_emit3", in_ready3, 0);
        words3++;
      end
      if (wd3) begin
        wd_cnt3++;
        check("words_per_window3", words3, 9);
        words3 = 0;
      end
      if (fd3) begin
        fd_cnt3++;
        check("fd_with_wd3", wd3, 1);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send4(input logic [31:0] d);
    int n = 0;
    while (!in_ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout4", 1, 0);
    end else begin
      in_valid4 = 1'b1;
      in_data4  = d;
      @(negedge clk);
      in_valid4 = 1'b0;
    end
  endtask

  task automatic send3(input logic [31:0] d);
    int n = 0;
    while (!in_ready3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout3", 1, 0);
    end else begin
      in_valid3 = 1'b1;
      in_data3  = d;
      @(negedge clk);
      in_valid3 = 1'b0;
    end
  endtask

  task automatic send_pixels4(input int base, input int from, input int to, input int gapmax);
    for (int i = from; i <= to; i++) begin
      int r = i / 4;
      int c = i % 4;
      img4[r][c] = base + vec4[i].pix;
      if (vec4[i].trig)
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            q4.push_back(img4[r-2+a][c-2+b]);
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send4(img4[r][c]);
    end
  endtask

  task automatic send_frame3(input int base);
    for (int i = 0; i < 9; i++) begin
      int r = i / 3;
      int c = i % 3;
      img3[r][c] = base + vec3[i].pix;
      if (vec3[i].trig)
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            q3.push_back(img3[r-2+a][c-2+b]);
      send3(img3[r][c]);
    end
  endtask

  task automatic frame_end4(input string tag, input int wd0, input int fd0);
    repeat (14) @(negedge clk);
    check({tag, "_queue_empty"}, q4.size(), 0);
    check({tag, "_windows"}, wd_cnt4 - wd0, 4);
    check({tag, "_framedone"}, fd_cnt4 - fd0, 1);
  endtask

  initial begin
    int wd0, fd0;
    longint acc;

    // Window triggers at row>=2 && col>=2; frame end at the final pixel.
    for (int i = 0; i < 16; i++) begin
      vec4[i].pix  = i;
      vec4[i].trig = (i == 10) || (i == 11) || (i == 14) || (i == 15);
      vec4[i].last = (i == 15);
    end
    for (int i = 0; i < 9; i++) begin
      vec3[i].pix  = i;
      vec3[i].trig = (i == 8);
      vec3[i].last = (i == 8);
    end

    rst4 = 1'b0; rst3 = 1'b0;
    in_valid4 = 1'b0; in_valid3 = 1'b0;
    in_data4 = '0; in_data3 = '0;
    #1;
    check("rst_outvalid", out_valid4, 0);
    check("rst_outdata", out_data4, 0);
    check("rst_windowdone", wd4, 0);
    check("rst_framedone", fd4, 0);
    check("rst_inready", in_ready4, 1);
    repeat (2) @(negedge clk);
    rst4 = 1'b1; rst3 = 1'b1;
    @(negedge clk);

    // Basic frame, with hand timing/accelerator check around pixel 10.
    wd0 = wd_cnt4; fd0 = fd_cnt4;
    send_pixels4(0, 0, 10, 0);
    acc = 0;
    for (int t = 1; t <= 9; t++) begin
      check("tim_outvalid", out_valid4, 1);
      check("tim_inready", in_ready4, 0);
      check("tim_word", out_data4, first_win[t-1]);
      acc += (longint'($signed(out_data4)) * longint'(coef[t-1])) >>> 24;
      @(negedge clk);
    end
    check("tim_windowdone", wd4, 1);
    check("tim_gap_outvalid", out_valid4, 0);
    check("tim_hold_outdata", out_data4, 10);
    check("tim_gap_inready", in_ready4, 1);
    check("accel_identity", acc, 5);
    send_pixels4(0, 11, 15, 0);
    frame_end4("basic", wd0, fd0);

    // Second frame streamed straight after: consecutive frames on 4x4.
    wd0 = wd_cnt4; fd0 = fd_cnt4;
    send_pixels4(100, 0, 15, 0);
    frame_end4("frame2", wd0, fd0);

    // Random input gaps.
    wd0 = wd_cnt4; fd0 = fd_cnt4;
    send_pixels4(200, 0, 15, 3);
    frame_end4("backpressure", wd0, fd0);

    // Reset during the 4th EMIT cycle of the first window.
    send_pixels4(300, 0, 10, 0);
    repeat (3) @(negedge clk);
    #2 rst4 = 1'b0;
    #1;
    check("midrst_outvalid", out_valid4, 0);
    check("midrst_inready", in_ready4, 1);
    q4.delete();
    words4 = 0;
    repeat (2) @(negedge clk);
    rst4 = 1'b1;
    repeat (3) @(negedge clk);
    wd0 = wd_cnt4; fd0 = fd_cnt4;
    send_pixels4(400, 0, 15, 0);
    frame_end4("after_reset", wd0, fd0);

    // Minimum image, two consecutive frames.
    send_frame3(1);
    send_frame3(101);
    repeat (14) @(negedge clk);
    check("min_queue_empty", q3.size(), 0);
    check("min_windows", wd_cnt3, 2);
    check("min_framedone", fd_cnt3, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
